biquad_ctrl: RTL
================

BIQUAD_CTRL -- requirements
Module: biquad_ctrl

Interface
REQ-001 SHALL have parameter opsize, default 8; it sets the sample and coefficient width, and the mac operand width.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: x_in carries a new sample.
REQ-005 SHALL have port in_ready, output, 1: high only in IDLE; a sample is accepted when in_valid && in_ready.
REQ-006 SHALL have port x_in, input, opsize: signed Q1.(opsize-1) sample.
REQ-007 SHALL have port coef_we, input, 1: coefficient write strobe.
REQ-008 SHALL have port coef_addr, input, 3: 0=b0, 1=b1, 2=b2, 3=-a1, 4=-a2; addresses 5-7 are ignored.
REQ-009 SHALL have port coef_data, input, opsize: signed Q1.(opsize-1) coefficient.
REQ-010 SHALL have port y_out, output, opsize: signed filter output.
REQ-011 SHALL have port out_valid, output, 1: one-cycle pulse when y_out updates.
REQ-012 SHALL have ports mac_start (output, 1), mac_reset (output, 1), mac_a and mac_b (output, opsize each): drive the shared mac.
REQ-013 SHALL have ports mac_out (input, 2*opsize) and mac_ready (input, 1): accumulator value and idle flag from the mac.

Function
REQ-014 SHALL compute y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + (-a1)*y[n-1] + (-a2)*y[n-2] using five sequential mac operations, in tap order 0..4.
REQ-015 SHALL use the FSM states IDLE -> CLEAR -> ISSUE -> WAIT_LO -> WAIT_HI -> (ISSUE for the next tap | OUTPUT) -> IDLE.
REQ-016 In IDLE, on sample acceptance, SHALL latch x_in, set the tap index to 0, and enter CLEAR.
REQ-017 CLEAR SHALL drive mac_reset=1 for exactly one cycle and then enter ISSUE.
REQ-018 ISSUE SHALL drive mac_start=1 for exactly one cycle, with mac_a=coef[tap] and mac_b=operand[tap] (x, x1, x2, y1, y2), and then enter WAIT_LO.
REQ-019 mac_a and mac_b SHALL remain stable from ISSUE until WAIT_HI exits.
REQ-020 WAIT_LO SHALL wait until mac_ready==0, then enter WAIT_HI.
REQ-021 WAIT_HI SHALL wait until mac_ready==1, then increment the tap index; it SHALL enter OUTPUT after tap 4 and ISSUE otherwise.
REQ-022 OUTPUT SHALL set y_out=fmt(mac_out >>> (opsize-1)), arithmetic shift, and pulse out_valid.
REQ-023 OUTPUT SHALL shift the delay line: x2<=x1, x1<=x, y2<=y1, y1<=y_out(new); it then enters IDLE.
REQ-024 Latency from accept to out_valid SHALL be 2 + sum over the five taps of (1 + WAIT_LO cycles + WAIT_HI cycles).
REQ-025 in_valid outside IDLE SHALL be ignored; no sample is queued.
REQ-026 coef_we SHALL take effect only in IDLE; writes in any other state are dropped.
REQ-027 When in IDLE, coef_we and in_valid in the same cycle SHALL both be taken; the coefficient is written and the sample is accepted.
REQ-028 The sample accepted in that case SHALL use the newly written coefficient.
REQ-029 mac_start and mac_reset SHALL be 0 in all states other than those stated above.
REQ-030 y_out SHALL hold its value between outputs.

Reset
REQ-031 reset SHALL return the FSM to IDLE from any state.
REQ-032 reset SHALL clear the tap index, the x/x1/x2/y1/y2 registers, all five coefficients, y_out, out_valid, mac_start, mac_a and mac_b to 0.
REQ-033 reset SHALL drive mac_reset=1 while it is asserted.
REQ-034 reset asserted mid-computation SHALL discard the partial result; no out_valid is produced for the aborted sample.

Configuration
REQ-035 With macro BIQUAD_SAT_EN defined, fmt() SHALL saturate the shifted value to [-(2^(opsize-1)), 2^(opsize-1)-1].
REQ-036 Without BIQUAD_SAT_EN, fmt() SHALL take the low opsize bits (two's-complement wrap).

Verification (opsize=8, mac attached)
REQ-037 Write b0=64, all other coefficients 0, send x=100 -> y_out=50, with out_valid pulsed once.
REQ-038 Write b0=127, -a1=64, others 0, send x=100,0,0 -> y_out=99, 49, 24.
REQ-039 Write b0=127, b1=127, send x=127 then x=127 -> second y_out=127 with BIQUAD_SAT_EN defined, and -4 without it.
REQ-040 Hold in_valid high during computation and attempt coef_we while busy -> a single output results and the coefficients are unchanged.
REQ-041 Assert reset during tap 2 -> FSM returns to IDLE with no out_valid, and the next x=100 with b0=64 (rewritten) gives 50.
REQ-042 Every run -> mac_start and mac_reset are one-cycle pulses, with exactly five mac_start pulses per sample.

Source files
------------

// File: rtl/biquad_ctrl.sv
// Biquad sequencer: runs five taps through a shared external MAC, one per sample.
// Build option: define BIQUAD_SAT_EN to saturate the output instead of wrapping.
module biquad_ctrl #(
  parameter int unsigned opsize = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [opsize-1:0]   x_in,
  input  logic                       coef_we,
  input  logic [2:0]                 coef_addr,
  input  logic signed [opsize-1:0]   coef_data,
  output logic signed [opsize-1:0]   y_out,
  output logic                       out_valid,
  output logic                       mac_start,
  output logic                       mac_reset,
  output logic signed [opsize-1:0]   mac_a,
  output logic signed [opsize-1:0]   mac_b,
  input  logic signed [2*opsize-1:0] mac_out,
  input  logic                       mac_ready
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StWaitLo,
    StWaitHi,
    StOutput
  } state_e;

  state_e state_q, state_d;
  logic [2:0] tap_q, tap_d;
  logic signed [opsize-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [opsize-1:0] y1_q, y1_d, y2_q, y2_d;
  logic signed [opsize-1:0] y_out_q, y_out_d;
  logic out_valid_q, out_valid_d;
  logic signed [opsize-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic signed [opsize-1:0] coef_q [5];
  logic signed [opsize-1:0] coef_d [5];
  logic signed [opsize-1:0] tap_coef, tap_opnd;
  logic signed [2*opsize-1:0] shifted;
  logic signed [opsize-1:0] y_fmt;

  assign shifted = mac_out >>> (opsize - 1);

`ifdef BIQUAD_SAT_EN
  localparam logic signed [2*opsize-1:0] SatMax = {{(opsize+1){1'b0}}, {(opsize-1){1'b1}}};
  localparam logic signed [2*opsize-1:0] SatMin = {{(opsize+1){1'b1}}, {(opsize-1){1'b0}}};

  always_comb begin
    if (shifted > SatMax) begin
      y_fmt = SatMax[opsize-1:0];
    end else if (shifted < SatMin) begin
      y_fmt = SatMin[opsize-1:0];
    end else begin
      y_fmt = shifted[opsize-1:0];
    end
  end
`else
  logic unused_shifted_hi;

  assign y_fmt             = shifted[opsize-1:0];
  assign unused_shifted_hi = ^shifted[2*opsize-1:opsize];
`endif

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y_out_d     = y_out_q;
    out_valid_d = 1'b0;
    coef_d      = coef_q;

    case (state_q)
      StIdle: begin
        // Coefficient is written on the same edge as a sample is accepted, so
        // that sample's first ISSUE already sees the new value.
        if (coef_we) begin
          case (coef_addr)
            3'd0:    coef_d[0] = coef_data;
            3'd1:    coef_d[1] = coef_data;
            3'd2:    coef_d[2] = coef_data;
            3'd3:    coef_d[3] = coef_data;
            3'd4:    coef_d[4] = coef_data;
            default: ;
          endcase
        end
        if (in_valid) begin
          x_d     = x_in;
          tap_d   = 3'd0;
          state_d = StClear;
        end
      end
      StClear:  state_d = StIssue;
      StIssue:  state_d = StWaitLo;
      StWaitLo: begin
        if (!mac_ready) state_d = StWaitHi;
      end
      StWaitHi: begin
        if (mac_ready) begin
          tap_d = tap_q + 3'd1;
          if (tap_q == 3'd4) begin
            // Result is registered here so y_out/out_valid are visible during OUTPUT.
            state_d     = StOutput;
            y_out_d     = y_fmt;
            out_valid_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StOutput: begin
        x2_d    = x1_q;
        x1_d    = x_q;
        y2_d    = y1_q;
        y1_d    = y_out_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tap_coef = '0;
    tap_opnd = '0;
    case (tap_d)
      3'd0: begin
        tap_coef = coef_q[0];
        tap_opnd = x_q;
      end
      3'd1: begin
        tap_coef = coef_q[1];
        tap_opnd = x1_q;
      end
      3'd2: begin
        tap_coef = coef_q[2];
        tap_opnd = x2_q;
      end
      3'd3: begin
        tap_coef = coef_q[3];
        tap_opnd = y1_q;
      end
      3'd4: begin
        tap_coef = coef_q[4];
        tap_opnd = y2_q;
      end
      default: ;
    endcase
  end

  // Operands load only on entry to ISSUE and hold through the MAC wait.
  always_comb begin
    mac_a_d = mac_a_q;
    mac_b_d = mac_b_q;
    if (state_d == StIssue) begin
      mac_a_d = tap_coef;
      mac_b_d = tap_opnd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      for (int i = 0; i < 5; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      y_out_q     <= y_out_d;
      out_valid_q <= out_valid_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      coef_q      <= coef_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign mac_start = (state_q == StIssue) && !reset;
  assign mac_reset = reset || (state_q == StClear);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;

endmodule
